rca_chunk_sequencer: RTL and testbench
======================================

// Module: rca_chunk_sequencer
// PURPOSE
//  Multi-cycle controller that performs a DATA_W-bit add on one external CHUNK_W-bit
//  ripple-carry adder (e.g. RCA_16bit). Operands are fed chunk by chunk, LSB chunk
//  first. The controller waits SETTLE cycles per chunk for the ripple to settle,
//  then chains the carry into the next chunk. Sits between a valid/ready producer
//  and consumer; the adder instance is outside this block.
// PARAMETERS
//  DATA_W   32  operand/result width; must be an integer multiple of CHUNK_W
//  CHUNK_W  16  width of the external adder
//  SETTLE   32  cycles a chunk's inputs are held before its sum is sampled; >=1
//               (32 x 10 ns covers worst-case 16-bit ripple of the gate library)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        reset, asynchronous, active-low
//  in_valid   in   1        operand request valid
//  in_ready   out  1        controller can accept operands
//  in_a       in   DATA_W   operand A
//  in_b       in   DATA_W   operand B
//  in_cin     in   1        carry-in to LSB chunk
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_sum    out  DATA_W   a+b+cin, modulo 2^DATA_W
//  out_cout   out  1        carry out of MSB chunk
//  busy       out  1        high in WAIT or DONE
//  add_a      out  CHUNK_W  to adder a   (registered)
//  add_b      out  CHUNK_W  to adder b   (registered)
//  add_cin    out  1        to adder cin (registered)
//  add_sum    in   CHUNK_W  from adder sum
//  add_cout   in   1        from adder cout
// BEHAVIOUR
//  - NCHUNK = DATA_W/CHUNK_W. Elaboration error if DATA_W%CHUNK_W!=0 or SETTLE<1.
//  - Reset (rst_n=0, any time, incl. mid-op): state=IDLE, idx=0, cnt=0; all operand,
//    sum and carry regs 0; in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0,
//    add_a/add_b/add_cin=0. An in-flight operation is discarded, no output.
//  - States: IDLE, WAIT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  - IDLE: on in_valid&&in_ready, latch in_a/in_b, carry<=in_cin, idx<=0,
//    cnt<=SETTLE-1, go to WAIT. No accept in WAIT or DONE (no overlap).
//  - add_a/add_b = chunk idx of the latched operands; add_cin = carry reg. These
//    change only on accept or on idx advance; they are stable for the whole of WAIT.
//  - WAIT: if cnt!=0, cnt<=cnt-1. If cnt==0: sum_reg[idx chunk]<=add_sum,
//    carry<=add_cout. Then if idx==NCHUNK-1, go to DONE; otherwise
//    idx<=idx+1, cnt<=SETTLE-1, stay in WAIT.
//  - Timing: with accept at edge 0, chunk i is sampled at edge (i+1)*SETTLE, and
//    out_valid rises at edge NCHUNK*SETTLE (default 64 cycles).
//  - DONE: out_sum=sum_reg, out_cout=carry. Both are held stable while out_valid &&
//    !out_ready. On out_ready, go to IDLE at that edge; in_ready rises the next
//    cycle. A new accept takes one or more idle cycles after the handshake.
//  - out_sum/out_cout keep their last value in IDLE; they are valid only with out_valid.
//  - in_* inputs are ignored outside the accept cycle.
//  - Carry chaining: the carry out of chunk i is the carry in to chunk i+1. Overflow
//    wraps: the result is modulo 2^DATA_W and the overflow bit is out_cout.
// TESTING (bench instantiates RCA_16bit on add_*, clk period 10 ns, defaults)
//  1 a=0x0000_0001,b=0x0000_0002,cin=0 -> out_sum=0x0000_0003,cout=0, out_valid @ edge 64
//  2 a=0x0000_FFFF,b=0x0000_0001,cin=0 -> out_sum=0x0001_0000,cout=0 (inter-chunk carry)
//  3 a=0xFFFF_FFFF,b=0x0000_0000,cin=1 -> out_sum=0x0000_0000,cout=1 (full ripple, wrap)
//  4 out_ready held 0 for 10 cycles after out_valid -> sum stable, in_ready=0, and an
//    in_valid pulse is ignored; out_ready=1 -> IDLE, the next op is accepted normally
//  5 rst_n low for 1 cycle at edge 20 mid-op -> all outputs are reset values at once,
//    no out_valid; the next op a=0x1234_5678,b=0x1111_1111 -> 0x2345_6789
//  6 back-to-back: 100 random a,b,cin with out_ready=1 -> each matches the {cout,sum}
//    model, and add_a/add_b/add_cin never change during a WAIT window

Source files
------------

// File: rtl/rca_chunk_sequencer.sv
// rca_chunk_sequencer
//   Drives a DATA_W-bit addition through one external CHUNK_W-bit ripple-carry
//   adder, one chunk at a time, LSB chunk first. Each chunk's operands are held
//   on the adder for SETTLE cycles before its sum is sampled. The carry out of
//   each chunk becomes the carry in of the next chunk.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready          operand handshake; in_a, in_b, in_cin operands
//   out_valid/out_ready        result handshake; out_sum, out_cout result
//   busy                       operation in flight or result pending
//   add_a, add_b, add_cin      registered drive to the external adder
//   add_sum, add_cout          external adder result
module rca_chunk_sequencer #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 16,
  parameter int SETTLE  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_sum,
  output logic               out_cout,
  output logic               busy,
  output logic [CHUNK_W-1:0] add_a,
  output logic [CHUNK_W-1:0] add_b,
  output logic               add_cin,
  input  logic [CHUNK_W-1:0] add_sum,
  input  logic               add_cout
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  if ((DATA_W % CHUNK_W) != 0) begin : g_bad_width
    $error("rca_chunk_sequencer: DATA_W must be a multiple of CHUNK_W");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("rca_chunk_sequencer: SETTLE must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_r, state_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [DATA_W-1:0]   a_r, a_s;
  logic [DATA_W-1:0]   b_r, b_s;
  logic [DATA_W-1:0]   sum_r, sum_s;
  logic                carry_r, carry_s;
  logic [CHUNK_W-1:0]  add_a_r, add_a_s;
  logic [CHUNK_W-1:0]  add_b_r, add_b_s;
  logic [DATA_W-1:0]   out_sum_r, out_sum_s;
  logic                out_cout_r, out_cout_s;

  function automatic logic [CHUNK_W-1:0] chunk_of(input logic [DATA_W-1:0] v,
                                                 input logic [IDX_W-1:0]  i);
    chunk_of = v[i*CHUNK_W +: CHUNK_W];
  endfunction

  // State and datapath registers; everything clears on reset, aborting any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      cnt_r      <= '0;
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      carry_r    <= 1'b0;
      add_a_r    <= '0;
      add_b_r    <= '0;
      out_sum_r  <= '0;
      out_cout_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      cnt_r      <= cnt_s;
      a_r        <= a_s;
      b_r        <= b_s;
      sum_r      <= sum_s;
      carry_r    <= carry_s;
      add_a_r    <= add_a_s;
      add_b_r    <= add_b_s;
      out_sum_r  <= out_sum_s;
      out_cout_r <= out_cout_s;
    end
  end

  // Next-state and datapath update for the IDLE/WAIT/DONE sequence.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    a_s        = a_r;
    b_s        = b_r;
    sum_s      = sum_r;
    carry_s    = carry_r;
    add_a_s    = add_a_r;
    add_b_s    = add_b_r;
    out_sum_s  = out_sum_r;
    out_cout_s = out_cout_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          a_s     = in_a;
          b_s     = in_b;
          carry_s = in_cin;
          idx_s   = '0;
          cnt_s   = CNT_LOAD;
          add_a_s = in_a[CHUNK_W-1:0];
          add_b_s = in_b[CHUNK_W-1:0];
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r != '0) begin
          cnt_s = cnt_r - CNT_ONE;
        end else begin
          // Ripple has settled: capture this chunk and chain its carry.
          sum_s[idx_r*CHUNK_W +: CHUNK_W] = add_sum;
          carry_s = add_cout;
          if (idx_r == IDX_LAST) begin
            out_sum_s  = sum_s;
            out_cout_s = add_cout;
            state_s    = ST_DONE;
          end else begin
            idx_s   = idx_r + IDX_ONE;
            cnt_s   = CNT_LOAD;
            add_a_s = chunk_of(a_r, idx_s);
            add_b_s = chunk_of(b_r, idx_s);
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r == ST_WAIT) || (state_r == ST_DONE);
  assign out_sum   = out_sum_r;
  assign out_cout  = out_cout_r;
  assign add_a     = add_a_r;
  assign add_b     = add_b_r;
  assign add_cin   = carry_r;

endmodule

// File: tb/tb_rca_chunk_sequencer.sv
module tb_rca_chunk_sequencer;

  localparam int DATA_W  = 32;
  localparam int CHUNK_W = 16;
  localparam int SETTLE  = 32;
  localparam int NCHUNK  = DATA_W / CHUNK_W;
  localparam int PER     = 10;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_cin;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_cout;
  logic              busy;
  logic [CHUNK_W-1:0] add_a;
  logic [CHUNK_W-1:0] add_b;
  logic               add_cin;
  logic [CHUNK_W-1:0] add_sum;
  logic               add_cout;

  rca_chunk_sequencer #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // External 16-bit ripple-carry adder stand-in.
  assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  initial clk = 1'b0;
  always #(PER/2) clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic [DATA_W-1:0] sum;
    logic              cout;
    time               t_acc;
  } op_t;

  op_t q[$];
  op_t act;
  bit  act_v = 1'b0;
  op_t cur;
  bit  have_cur = 1'b0;
  bit  prev_valid = 1'b0;
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, actual, required, $time);
    end
  endtask

  // Reference: whole-word add, result modulo 2^DATA_W, overflow as cout.
  function automatic op_t make_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                  input logic cin);
    op_t o;
    longint unsigned s;
    s = longint'(a) + longint'(b) + longint'(cin);
    o.a = a; o.b = b; o.cin = cin;
    o.sum = DATA_W'(s);
    o.cout = 1'((s >> DATA_W) & 64'd1);
    o.t_acc = 0;
    return o;
  endfunction

  // Expected adder drive for chunk i: operand chunks plus carry out of all lower bits.
  function automatic logic [63:0] exp_drive(input op_t o, input int i);
    longint unsigned m, s;
    logic [CHUNK_W-1:0] ca, cb;
    logic c;
    ca = CHUNK_W'(o.a >> (i*CHUNK_W));
    cb = CHUNK_W'(o.b >> (i*CHUNK_W));
    m  = (64'd1 << (i*CHUNK_W)) - 64'd1;
    s  = (longint'(o.a) & m) + (longint'(o.b) & m) + longint'(o.cin);
    c  = 1'((s >> (i*CHUNK_W)) & 64'd1);
    return 64'({c, cb, ca});
  endfunction

  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic cin);
    op_t o;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'd0, 64'd1);
    end else begin
      o = make_op(a, b, cin);
      o.t_acc = $time + PER/2;
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
      q.push_back(o);
      act = o;
      act_v = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(q.size() == 0 && in_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(q.size() == 0 && in_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_out_sum"}, 64'(out_sum), 64'd0);
    check({tag, "_out_cout"}, 64'(out_cout), 64'd0);
    check({tag, "_add_drive"}, 64'({add_cin, add_b, add_a}), 64'd0);
  endtask

  // Adder drive monitor: within an operation, chunk k/SETTLE must be presented steadily.
  always @(negedge clk) begin
    longint k;
    int i;
    if (rst_n && act_v && busy && !out_valid) begin
      k = longint'($time - act.t_acc - PER/2) / PER;
      i = int'(k / SETTLE);
      if (i >= NCHUNK) begin
        check("wait_too_long", 64'(k), 64'(NCHUNK*SETTLE - 1));
      end else begin
        check("add_drive", 64'({add_cin, add_b, add_a}), exp_drive(act, i));
      end
    end
  end

  // Result monitor: pops one expectation per out_valid episode and checks it every held cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!prev_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
          have_cur <= 1'b0;
        end else begin
          cur = q.pop_front();
          have_cur <= 1'b1;
          check("latency", 64'($time - cur.t_acc), 64'(NCHUNK*SETTLE*PER + PER/2));
          check("out_sum", 64'(out_sum), 64'(cur.sum));
          check("out_cout", 64'(out_cout), 64'(cur.cout));
          check("in_ready_done", 64'(in_ready), 64'd0);
        end
      end else if (have_cur) begin
        check("held_out_sum", 64'(out_sum), 64'(cur.sum));
        check("held_out_cout", 64'(out_cout), 64'(cur.cout));
        check("held_in_ready", 64'(in_ready), 64'd0);
      end
    end
    prev_valid <= rst_n && out_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: simple add, inter-chunk carry, full ripple with wrap.
    send(32'h0000_0001, 32'h0000_0002, 1'b0);
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_idle();

    // Consumer back-pressure: result held, no accept while DONE.
    out_ready = 1'b0;
    send($urandom, $urandom, 1'($urandom_range(0, 1)));
    begin
      int n;
      n = 0;
      while (!out_valid && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("bp_out_valid_seen", 64'(out_valid), 64'd1);
    end
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_a = $urandom; in_b = $urandom; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_out_valid_held", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
    wait_idle();

    // Mid-operation reset at edge 20 after accept.
    send($urandom, $urandom, 1'b1);
    repeat (19) @(negedge clk);
    #3;
    rst_n = 1'b0;
    q.delete();
    act_v = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_idle();
    check("post_reset_sum", 64'(out_sum), 64'h2345_6789);

    // Back-to-back random operations.
    for (int n = 0; n < 100; n++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
